maze_solver: RTL and testbench
==============================

MAZE_SOLVER -- requirements
Module: maze_solver

Interface
REQ-001 Parameter size, default 8: maze edge length in cells.
REQ-002 Parameter N, default $clog2(size): coordinate width.
REQ-003 Parameter LIMIT, default 4*size*size: maximum moves before giving up.
REQ-004 clk  input  1  single clock; all state updates on posedge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 maze  input  [size-1:0] x size (unpacked rows)  maze[y][x]: 1 = wall, 0 = open; same layout mazegen drives.
REQ-007 start  input  1  request solve; sampled only in IDLE.
REQ-008 sx, sy  input  N each  start cell coordinates.
REQ-009 gx, gy  input  N each  goal cell coordinates.
REQ-010 sdir  input  2  initial heading: 0=N(y-1), 1=E(x+1), 2=S(y+1), 3=W(x-1).
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 done  output  1  one-cycle pulse in FOUND or FAIL.
REQ-013 found, fail  output  1 each  result flags, held until the next accepted start.
REQ-014 pos_x, pos_y  output  N each  current cell.
REQ-015 pos_valid  output  1  one-cycle pulse per move; pos_x/pos_y are the new cell.
REQ-016 steps  output  $clog2(LIMIT+1)  moves taken since the accepted start.

Function
REQ-017 States: IDLE, CHECK, WALK, FOUND, FAIL.
REQ-018 IDLE with start=1: latch maze, sx/sy, gx/gy, sdir; clear steps/found/fail; go to CHECK.
REQ-019 start outside IDLE is ignored; the latched maze is unaffected by later maze changes.
REQ-020 CHECK: start or goal cell is a wall, or a coordinate >= size -> FAIL; else pos==goal -> FOUND (steps=0); else WALK.
REQ-021 WALK, right-hand rule, one move per cycle; priority: turn right, straight, turn left, reverse.
REQ-022 First open candidate: heading becomes that direction, pos moves one cell, steps+1, pos_valid=1.
REQ-023 Out-of-bounds neighbours count as walls; no coordinate wrap-around.
REQ-024 All four neighbours walled -> FAIL with no move.
REQ-025 New pos==goal -> FOUND next cycle.
REQ-026 steps reaches LIMIT without reaching goal -> FAIL next cycle; steps saturates at LIMIT.
REQ-027 FOUND: found=1, done=1. FAIL: fail=1, done=1. Both states return to IDLE after one cycle.
REQ-028 Latency: start at cycle 0 -> CHECK at 1 -> first move at 2 -> done at cycle (k+2) for a k-move solution (k>=1).

Reset
REQ-029 Reset state: IDLE.
REQ-030 Output reset values: busy=0, done=0, found=0, fail=0, pos_valid=0, pos_x=0, pos_y=0, steps=0.
REQ-031 Internal heading resets to 0.
REQ-032 Reset is effective immediately in any state, including mid-WALK; no done pulse is issued.

Structure
REQ-033 Package maze_pkg holds dir_t (N/E/S/W), state_t, and turn functions right/left/reverse on dir_t.
REQ-034 Sub-module maze_nbr, combinational: from the latched maze, pos, and heading, outputs wall flags for right, ahead, left, back, including bounds checks.

Verification (size=8, LIMIT=256)
REQ-035 Only row 0 open; start (0,0), sdir=E, goal (7,0) -> 7 pos_valid pulses along x=1..7, done at cycle 9, found=1, steps=7.
REQ-036 start=(3,3)=goal, open cell -> done at cycle 2, found=1, steps=0, no pos_valid.
REQ-037 Start cell (2,2) is a wall -> done at cycle 2, fail=1, steps=0.
REQ-038 Row 0 corridor, goal (5,5) open but isolated -> corridor shuttle, fail=1, steps=256, done at cycle 259.
REQ-039 rst low at cycle 5 mid-WALK -> all outputs at reset values immediately; fresh start afterwards completes REQ-035 normally.
REQ-040 Start pulses during WALK, with maze inputs changed -> ignored; result identical to REQ-035.

Source files
------------

// File: rtl/maze_pkg.sv
// Shared types for the maze solver: compass headings, FSM states and
// heading rotation helpers.
package maze_pkg;

  typedef enum logic [1:0] {
    DirN = 2'd0,
    DirE = 2'd1,
    DirS = 2'd2,
    DirW = 2'd3
  } dir_t;

  typedef enum logic [2:0] {
    StIdle,
    StCheck,
    StWalk,
    StFound,
    StFail
  } state_t;

  function automatic dir_t right(dir_t d);
    return dir_t'(d + 2'd1);
  endfunction

  function automatic dir_t left(dir_t d);
    return dir_t'(d + 2'd3);
  endfunction

  function automatic dir_t reverse(dir_t d);
    return dir_t'(d + 2'd2);
  endfunction

endpackage

// File: rtl/maze_nbr.sv
// Combinational neighbour lookup: wall flags relative to the current heading,
// with cells beyond the maze edge reported as walls.
module maze_nbr
  import maze_pkg::*;
#(
  parameter int unsigned size = 8,
  parameter int unsigned N    = $clog2(size)
) (
  input  logic [size-1:0] maze [size],
  input  logic [N-1:0]    pos_x,
  input  logic [N-1:0]    pos_y,
  input  dir_t            dir,
  output logic            wall_right,
  output logic            wall_ahead,
  output logic            wall_left,
  output logic            wall_back
);

  // Indexed by absolute heading.
  logic [3:0] wall_abs;

  always_comb begin
    wall_abs = 4'b1111;
    if (pos_y != '0) begin
      wall_abs[DirN] = maze[pos_y - N'(1)][pos_x];
    end
    if (pos_x != N'(size - 1)) begin
      wall_abs[DirE] = maze[pos_y][pos_x + N'(1)];
    end
    if (pos_y != N'(size - 1)) begin
      wall_abs[DirS] = maze[pos_y + N'(1)][pos_x];
    end
    if (pos_x != '0) begin
      wall_abs[DirW] = maze[pos_y][pos_x - N'(1)];
    end
  end

  assign wall_right = wall_abs[right(dir)];
  assign wall_ahead = wall_abs[dir];
  assign wall_left  = wall_abs[left(dir)];
  assign wall_back  = wall_abs[reverse(dir)];

endmodule

// File: rtl/maze_solver.sv
// Right-hand-rule maze walker: latches a maze and endpoints on start, then
// makes one move per cycle until the goal is reached, it is trapped, or the
// move budget runs out.
module maze_solver
  import maze_pkg::*;
#(
  parameter int unsigned size  = 8,
  parameter int unsigned N     = $clog2(size),
  parameter int unsigned LIMIT = 4 * size * size
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [size-1:0]            maze [size],
  input  logic                       start,
  input  logic [N-1:0]               sx,
  input  logic [N-1:0]               sy,
  input  logic [N-1:0]               gx,
  input  logic [N-1:0]               gy,
  input  logic [1:0]                 sdir,
  output logic                       busy,
  output logic                       done,
  output logic                       found,
  output logic                       fail,
  output logic [N-1:0]               pos_x,
  output logic [N-1:0]               pos_y,
  output logic                       pos_valid,
  output logic [$clog2(LIMIT+1)-1:0] steps
);

  localparam int unsigned SW = $clog2(LIMIT + 1);

  state_t          state_q, state_d;
  logic [size-1:0] maze_q [size];
  logic [N-1:0]    px_q, px_d, py_q, py_d;
  logic [N-1:0]    gx_q, gy_q;
  dir_t            dir_q, dir_d;
  logic [SW-1:0]   steps_q, steps_d;
  logic            found_q, found_d, fail_q, fail_d, pv_q, pv_d;
  logic            load;

  logic            wall_right, wall_ahead, wall_left, wall_back;
  logic            start_oob, goal_oob, start_wall, goal_wall;
  logic            can_move;
  dir_t            mv;
  logic [N-1:0]    nx, ny;

  maze_nbr #(
    .size(size),
    .N   (N)
  ) u_nbr (
    .maze      (maze_q),
    .pos_x     (px_q),
    .pos_y     (py_q),
    .dir       (dir_q),
    .wall_right(wall_right),
    .wall_ahead(wall_ahead),
    .wall_left (wall_left),
    .wall_back (wall_back)
  );

  // Guard the array lookups so a bad coordinate never indexes past the maze.
  assign start_oob  = (32'(px_q) >= size) || (32'(py_q) >= size);
  assign goal_oob   = (32'(gx_q) >= size) || (32'(gy_q) >= size);
  assign start_wall = start_oob ? 1'b1 : maze_q[py_q][px_q];
  assign goal_wall  = goal_oob ? 1'b1 : maze_q[gy_q][gx_q];

  always_comb begin
    can_move = 1'b1;
    mv       = dir_q;
    if (!wall_right) begin
      mv = right(dir_q);
    end else if (!wall_ahead) begin
      mv = dir_q;
    end else if (!wall_left) begin
      mv = left(dir_q);
    end else if (!wall_back) begin
      mv = reverse(dir_q);
    end else begin
      can_move = 1'b0;
    end

    nx = px_q;
    ny = py_q;
    unique case (mv)
      DirN: ny = py_q - N'(1);
      DirE: nx = px_q + N'(1);
      DirS: ny = py_q + N'(1);
      DirW: nx = px_q - N'(1);
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    px_d    = px_q;
    py_d    = py_q;
    dir_d   = dir_q;
    steps_d = steps_q;
    found_d = found_q;
    fail_d  = fail_q;
    pv_d    = 1'b0;
    load    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          load    = 1'b1;
          px_d    = sx;
          py_d    = sy;
          dir_d   = dir_t'(sdir);
          steps_d = '0;
          found_d = 1'b0;
          fail_d  = 1'b0;
          state_d = StCheck;
        end
      end
      StCheck: begin
        if (start_wall || goal_wall) begin
          fail_d  = 1'b1;
          state_d = StFail;
        end else if (px_q == gx_q && py_q == gy_q) begin
          found_d = 1'b1;
          state_d = StFound;
        end else begin
          state_d = StWalk;
        end
      end
      StWalk: begin
        // Budget is checked before moving, so the give-up costs one extra cycle.
        if (steps_q >= SW'(LIMIT) || !can_move) begin
          fail_d  = 1'b1;
          state_d = StFail;
        end else begin
          dir_d   = mv;
          px_d    = nx;
          py_d    = ny;
          steps_d = steps_q + SW'(1);
          pv_d    = 1'b1;
          if (nx == gx_q && ny == gy_q) begin
            found_d = 1'b1;
            state_d = StFound;
          end
        end
      end
      StFound, StFail: state_d = StIdle;
      default:         state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      px_q    <= '0;
      py_q    <= '0;
      dir_q   <= DirN;
      steps_q <= '0;
      found_q <= 1'b0;
      fail_q  <= 1'b0;
      pv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      px_q    <= px_d;
      py_q    <= py_d;
      dir_q   <= dir_d;
      steps_q <= steps_d;
      found_q <= found_d;
      fail_q  <= fail_d;
      pv_q    <= pv_d;
    end
  end

  // Maze snapshot and goal are plain datapath, only written on an accepted start.
  always_ff @(posedge clk) begin
    if (load) begin
      maze_q <= maze;
      gx_q   <= gx;
      gy_q   <= gy;
    end
  end

  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StFound) || (state_q == StFail);
  assign found     = found_q;
  assign fail      = fail_q;
  assign pos_x     = px_q;
  assign pos_y     = py_q;
  assign pos_valid = pv_q;
  assign steps     = steps_q;

endmodule

// File: tb/tb_maze_solver.sv
// Directed bench for maze_solver with a path-tracing reference model.
module tb_maze_solver;

  localparam int SIZE = 8;
  localparam int LIM  = 256;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] maze_in [8];
  logic       start = 1'b0;
  logic [2:0] sx = '0, sy = '0, gx = '0, gy = '0;
  logic [1:0] sdir = '0;
  logic       busy, done, found, fail, pos_valid;
  logic [2:0] pos_x, pos_y;
  logic [8:0] steps;

  always #5 clk = ~clk;

  maze_solver #(
    .size (SIZE),
    .LIMIT(LIM)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .maze     (maze_in),
    .start    (start),
    .sx       (sx),
    .sy       (sy),
    .gx       (gx),
    .gy       (gy),
    .sdir     (sdir),
    .busy     (busy),
    .done     (done),
    .found    (found),
    .fail     (fail),
    .pos_x    (pos_x),
    .pos_y    (pos_y),
    .pos_valid(pos_valid),
    .steps    (steps)
  );

  int ncmp = 0;
  int nerr = 0;

  // Model results for the current solve.
  int m_k, m_dc, m_sx, m_sy;
  bit m_found;
  int m_px [LIM];
  int m_py [LIM];

  bit active = 1'b0;
  int cyc = 0;
  int done_cyc = -1;

  task automatic chk(input string name, input int act, input int exp);
    ncmp++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic bit is_open(input int x, input int y);
    if (x < 0 || x >= SIZE || y < 0 || y >= SIZE) return 1'b0;
    return maze_in[y][x] == 1'b0;
  endfunction

  task automatic fill(input bit wall);
    for (int r = 0; r < SIZE; r++) maze_in[r] = wall ? 8'hff : 8'h00;
  endtask

  task automatic open_cell(input int x, input int y);
    maze_in[y][x] = 1'b0;
  endtask

  // Trace the right-hand-rule walk on the grid directly.
  task automatic model();
    int x, y, h, nh;
    bit moved;
    int dx [4];
    int dy [4];
    int ord [4];
    dx = '{0, 1, 0, -1};
    dy = '{-1, 0, 1, 0};
    ord = '{1, 0, 3, 2};
    x = int'(sx); y = int'(sy); h = int'(sdir);
    m_sx = x; m_sy = y; m_k = 0; m_found = 1'b0; m_dc = 2;
    if (!is_open(x, y) || !is_open(int'(gx), int'(gy))) return;
    if (x == int'(gx) && y == int'(gy)) begin
      m_found = 1'b1;
      return;
    end
    for (int it = 0; it <= LIM; it++) begin
      if (m_k == LIM) begin
        m_dc = m_k + 3;
        return;
      end
      moved = 1'b0;
      for (int i = 0; i < 4; i++) begin
        nh = (h + ord[i]) % 4;
        if (!moved && is_open(x + dx[nh], y + dy[nh])) begin
          h = nh; x += dx[nh]; y += dy[nh]; moved = 1'b1;
        end
      end
      if (!moved) begin
        m_dc = m_k + 3;
        return;
      end
      m_px[m_k] = x; m_py[m_k] = y; m_k++;
      if (x == int'(gx) && y == int'(gy)) begin
        m_found = 1'b1;
        m_dc = m_k + 2;
        return;
      end
    end
  endtask

  // Cycle c counts negedges after the edge that sampled start.
  always @(negedge clk) begin
    int ex, ey, ix;
    if (active) begin
      cyc++;
      if (done) done_cyc = cyc;
      if (cyc < 3 || m_k == 0) begin
        ex = m_sx; ey = m_sy;
      end else begin
        ix = imin(cyc - 3, m_k - 1);
        ex = m_px[ix]; ey = m_py[ix];
      end
      chk($sformatf("c%0d busy", cyc), int'(busy), int'(cyc <= m_dc));
      chk($sformatf("c%0d done", cyc), int'(done), int'(cyc == m_dc));
      chk($sformatf("c%0d found", cyc), int'(found), int'(cyc >= m_dc && m_found));
      chk($sformatf("c%0d fail", cyc), int'(fail), int'(cyc >= m_dc && !m_found));
      chk($sformatf("c%0d pos_valid", cyc), int'(pos_valid), int'(cyc >= 3 && cyc <= m_k + 2));
      chk($sformatf("c%0d pos_x", cyc), int'(pos_x), ex);
      chk($sformatf("c%0d pos_y", cyc), int'(pos_y), ey);
      chk($sformatf("c%0d steps", cyc), int'(steps), (cyc < 2) ? 0 : imin(cyc - 2, m_k));
    end
  end

  task automatic check_reset_vals(input string tag);
    chk({tag, " busy"}, int'(busy), 0);
    chk({tag, " done"}, int'(done), 0);
    chk({tag, " found"}, int'(found), 0);
    chk({tag, " fail"}, int'(fail), 0);
    chk({tag, " pos_valid"}, int'(pos_valid), 0);
    chk({tag, " pos_x"}, int'(pos_x), 0);
    chk({tag, " pos_y"}, int'(pos_y), 0);
    chk({tag, " steps"}, int'(steps), 0);
  endtask

  task automatic run(input int rst_at, input bit disturb);
    logic [7:0] saved [8];
    saved = maze_in;
    @(negedge clk);
    #1;
    start = 1'b1;
    model();
    cyc = 0;
    done_cyc = -1;
    active = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 1; i <= m_dc + 1; i++) begin
      @(negedge clk);
      #2;
      if (i == rst_at) begin
        rst = 1'b0;
        active = 1'b0;
        #1;
        check_reset_vals("midwalk reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        maze_in = saved;
        return;
      end
      if (disturb && (i == 3 || i == 5)) begin
        start = 1'b1;
        fill(1'b0);
        sx = 3'd5; sy = 3'd5; gx = 3'd1; gy = 3'd1;
      end else begin
        start = 1'b0;
      end
    end
    active = 1'b0;
    maze_in = saved;
  endtask

  task automatic setup_corridor();
    fill(1'b1);
    for (int x = 0; x < SIZE; x++) open_cell(x, 0);
    sx = 3'd0; sy = 3'd0; sdir = 2'd1; gx = 3'd7; gy = 3'd0;
  endtask

  initial begin
    fill(1'b0);
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b1;

    // Straight corridor along row 0.
    setup_corridor();
    run(0, 1'b0);
    chk("corridor model k", m_k, 7);
    chk("corridor done cycle", done_cyc, 9);
    chk("corridor steps", int'(steps), 7);
    chk("corridor found", int'(found), 1);

    // Start already at goal.
    fill(1'b0);
    sx = 3'd3; sy = 3'd3; gx = 3'd3; gy = 3'd3; sdir = 2'd0;
    run(0, 1'b0);
    chk("at-goal done cycle", done_cyc, 2);
    chk("at-goal found", int'(found), 1);
    chk("at-goal steps", int'(steps), 0);

    // Start cell is a wall.
    fill(1'b0);
    maze_in[2][2] = 1'b1;
    sx = 3'd2; sy = 3'd2; gx = 3'd5; gy = 3'd5; sdir = 2'd2;
    run(0, 1'b0);
    chk("wall-start done cycle", done_cyc, 2);
    chk("wall-start fail", int'(fail), 1);
    chk("wall-start steps", int'(steps), 0);

    // L-shaped path with a right turn at (3,0).
    fill(1'b1);
    for (int x = 0; x < 4; x++) open_cell(x, 0);
    for (int y = 1; y < 4; y++) open_cell(3, y);
    sx = 3'd0; sy = 3'd0; sdir = 2'd1; gx = 3'd3; gy = 3'd3;
    run(0, 1'b0);
    chk("L model k", m_k, 6);
    chk("L done cycle", done_cyc, 8);
    chk("L steps", int'(steps), 6);

    // Isolated start cell: trapped on the first walk cycle.
    fill(1'b1);
    open_cell(4, 4);
    open_cell(0, 0);
    sx = 3'd4; sy = 3'd4; gx = 3'd0; gy = 3'd0; sdir = 2'd3;
    run(0, 1'b0);
    chk("trap done cycle", done_cyc, 3);
    chk("trap fail", int'(fail), 1);

    // Unreachable goal: shuttle until the move budget is spent.
    setup_corridor();
    open_cell(5, 5);
    gx = 3'd5; gy = 3'd5;
    run(0, 1'b0);
    chk("limit done cycle", done_cyc, 259);
    chk("limit steps", int'(steps), 256);
    chk("limit fail", int'(fail), 1);

    // Reset mid-walk, then a clean rerun.
    setup_corridor();
    run(5, 1'b0);
    setup_corridor();
    run(0, 1'b0);
    chk("post-reset done cycle", done_cyc, 9);
    chk("post-reset steps", int'(steps), 7);

    // Start pulses and maze changes during the walk are ignored.
    setup_corridor();
    run(0, 1'b1);
    chk("disturb done cycle", done_cyc, 9);
    chk("disturb steps", int'(steps), 7);
    chk("disturb found", int'(found), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
